// File: rtl/reset_sequenced_pattern_gen.sv
// Reset-sequenced known-answer pattern source: release sequencing, seed load, then valid/ready streaming.
// Optional reset synchroniser on the internal release path is compiled in with RSTGEN_RST_SYNC_EN.
module reset_sequenced_pattern_gen #(
    parameter int               WIDTH       = 24,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(24'hC0FFEE),
    parameter int               MODE        = 0,
    parameter int               SYNC_STAGES = 2,
    parameter int               HOLDOFF     = 4,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             init_done,
    output logic [CNT_W-1:0] word_count
);

    // state    | meaning
    // WAIT_REL | waiting for the internal reset to release
    // HOLD     | counting out the hold-off interval
    // LOAD     | one cycle; seed is loaded on its exit edge
    // RUN      | streaming pattern words over valid/ready

    localparam int HC_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;

    typedef enum logic [1:0] {WAIT_REL, HOLD, LOAD, RUN} state_t;

    state_t          state;
    logic [HC_W-1:0] hold_cnt;
    logic            irst_n;
    logic            xfer;

`ifdef RSTGEN_RST_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign irst_n = sync_q[SYNC_STAGES-1];
`else
    assign irst_n = rst_n;
`endif

    function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w);
        case (MODE)
            1:       return w + WIDTH'(1);
            2:       return {w[WIDTH-2:0], w[WIDTH-1]};
            default: return w;
        endcase
    endfunction

    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_REL;
            hold_cnt   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            init_done  <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                WAIT_REL: begin
                    if (irst_n) begin
                        // With no hold-off the seed lands on the release edge itself, so
                        // first-valid latency stays at sync depth + HOLDOFF + 1 edges.
                        if (HOLDOFF == 0) begin
                            out_data  <= SEED;
                            init_done <= 1'b1;
                            out_valid <= enable;
                            state     <= RUN;
                        end else if (HOLDOFF == 1) begin
                            state <= LOAD;
                        end else begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HC_W'(1);
                    if (int'(hold_cnt) == HOLDOFF - 2) state <= LOAD;
                end
                LOAD: begin
                    out_data  <= SEED;
                    init_done <= 1'b1;
                    out_valid <= enable;
                    state     <= RUN;
                end
                RUN: begin
                    if (xfer) begin
                        out_data  <= next_word(out_data);
                        out_valid <= enable;
                        if (word_count != '1) word_count <= word_count + CNT_W'(1);
                    end else if (!out_valid) begin
                        out_valid <= enable;
                    end
                end
                default: state <= WAIT_REL;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequenced_pattern_gen.sv
// Bench for reset_sequenced_pattern_gen: five parameterisations driven in parallel and checked
// against a closed-form reference (edges since release, transfer count -> expected outputs).
module tb_reset_sequenced_pattern_gen;

`ifdef RSTGEN_RST_SYNC_EN
    localparam int S_LAT = 2;
`else
    localparam int S_LAT = 0;
`endif
    localparam int LAT_MAIN = S_LAT + 4 + 1;
    localparam int N = 5;

    logic        clk;
    logic        rst_n;
    logic        en  [N];
    logic        rdy [N];
    logic [23:0] o_data  [N];
    logic        o_valid [N];
    logic        o_init  [N];
    logic [7:0]  o_cnt   [N];
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;
    logic [3:0]  cnt4;

    int          compared;
    int          mismatched;

    int          e;
    int          lat   [N];
    int          modes [N];
    int          cmax  [N];
    logic [23:0] seeds [N];
    int          m_n   [N];
    bit          m_v   [N];

    assign o_cnt[0] = cnt0;
    assign o_cnt[1] = cnt1;
    assign o_cnt[2] = cnt2;
    assign o_cnt[3] = cnt3;
    assign o_cnt[4] = {4'b0, cnt4};

    reset_sequenced_pattern_gen #(.MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .out_ready(rdy[0]),
        .out_data(o_data[0]), .out_valid(o_valid[0]), .init_done(o_init[0]), .word_count(cnt0));
    reset_sequenced_pattern_gen #(.MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .out_ready(rdy[1]),
        .out_data(o_data[1]), .out_valid(o_valid[1]), .init_done(o_init[1]), .word_count(cnt1));
    reset_sequenced_pattern_gen #(.MODE(1), .SEED(24'hFFFFFF)) u1w (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .out_ready(rdy[2]),
        .out_data(o_data[2]), .out_valid(o_valid[2]), .init_done(o_init[2]), .word_count(cnt2));
    reset_sequenced_pattern_gen #(.MODE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .enable(en[3]), .out_ready(rdy[3]),
        .out_data(o_data[3]), .out_valid(o_valid[3]), .init_done(o_init[3]), .word_count(cnt3));
    reset_sequenced_pattern_gen #(.MODE(1), .CNT_W(4), .HOLDOFF(0)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(en[4]), .out_ready(rdy[4]),
        .out_data(o_data[4]), .out_valid(o_valid[4]), .init_done(o_init[4]), .word_count(cnt4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word after n accepted transfers, straight from the pattern definition.
    function automatic logic [23:0] pat(input int k, input int n);
        logic [23:0] s;
        int          r;
        s = seeds[k];
        r = n % 24;
        case (modes[k])
            1:       return s + 24'(n);
            2:       return (r == 0) ? s : ((s << r) | (s >> (24 - r)));
            default: return s;
        endcase
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            bit live;
            int c;
            live = (e >= lat[k]);
            c    = (m_n[k] > cmax[k]) ? cmax[k] : m_n[k];
            chk("valid", k, {31'b0, o_valid[k]}, {31'b0, live && m_v[k]});
            chk("init",  k, {31'b0, o_init[k]},  {31'b0, live});
            chk("data",  k, {8'b0, o_data[k]},   live ? {8'b0, pat(k, m_n[k])} : 32'b0);
            chk("count", k, {24'b0, o_cnt[k]},   32'(c));
        end
    endtask

    task automatic model_reset();
        e = 0;
        for (int k = 0; k < N; k++) begin
            m_n[k] = 0;
            m_v[k] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (e < 100000) e++;
        for (int k = 0; k < N; k++) begin
            if (e == lat[k]) begin
                m_v[k] = en[k];
                m_n[k] = 0;
            end else if (e > lat[k]) begin
                if (m_v[k] && rdy[k]) begin
                    m_n[k]++;
                    m_v[k] = en[k];
                end else if (!m_v[k]) begin
                    m_v[k] = en[k];
                end
            end
        end
        #1;
        check_all();
    endtask

    // Short asynchronous pulse, well inside one clock period.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic set_all(input logic en_v, input logic rdy_v);
        for (int k = 0; k < N; k++) begin
            en[k]  = en_v;
            rdy[k] = rdy_v;
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int k = 0; k < N; k++) begin
            lat[k]   = LAT_MAIN;
            cmax[k]  = 255;
            seeds[k] = 24'hC0FFEE;
        end
        modes[0] = 0; modes[1] = 1; modes[2] = 1; modes[3] = 2; modes[4] = 1;
        seeds[2] = 24'hFFFFFF;
        lat[4]   = S_LAT + 1;
        cmax[4]  = 15;

        rst_n = 1'b0;
        set_all(1'b1, 1'b1);
        #3;
        model_reset();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Release with enable and ready held high.
        repeat (LAT_MAIN - 1) step();
        chk("pre_valid", 0, {31'b0, o_valid[0]}, 32'd0);
        step();
        chk("seed_c0ffee", 0, {8'b0, o_data[0]}, 32'h00C0FFEE);
        chk("seed_ffffff", 2, {8'b0, o_data[2]}, 32'h00FFFFFF);
        chk("seed_rot",    3, {8'b0, o_data[3]}, 32'h00C0FFEE);
        step();
        chk("inc_once", 1, {8'b0, o_data[1]}, 32'h00C0FFEF);
        chk("inc_wrap", 2, {8'b0, o_data[2]}, 32'h00000000);
        chk("rot_once", 3, {8'b0, o_data[3]}, 32'h0081FFDD);

        // Stall the rotator for three cycles.
        rdy[3] = 1'b0;
        repeat (3) step();
        chk("rot_stall", 3, {8'b0, o_data[3]}, 32'h0081FFDD);
        chk("rot_stall_cnt", 3, {24'b0, o_cnt[3]}, 32'd1);
        rdy[3] = 1'b1;
        repeat (20) step();
        chk("sat15", 4, {24'b0, o_cnt[4]}, 32'd15);

        // Enable low at the load edge; enable wiggling earlier must not matter.
        pulse_reset();
        set_all(1'b0, 1'b1);
        for (int i = 1; i <= LAT_MAIN; i++) begin
            en[0] = (i < LAT_MAIN) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        chk("en_low_valid", 0, {31'b0, o_valid[0]}, 32'd0);
        chk("en_low_init",  0, {31'b0, o_init[0]},  32'd1);
        set_all(1'b0, 1'b1);
        repeat (2) step();
        set_all(1'b1, 1'b1);
        step();
        chk("en_rise", 0, {31'b0, o_valid[0]}, 32'd1);
        en[0]  = 1'b0;
        rdy[0] = 1'b0;
        repeat (3) step();
        chk("valid_held", 0, {31'b0, o_valid[0]}, 32'd1);
        rdy[0] = 1'b1;
        step();
        chk("valid_drop", 0, {31'b0, o_valid[0]}, 32'd0);

        // Mid-run abort with word_count at 5, then a full re-release.
        pulse_reset();
        set_all(1'b1, 1'b1);
        repeat (LAT_MAIN + 5) step();
        chk("cnt5", 1, {24'b0, o_cnt[1]}, 32'd5);
        pulse_reset();
        repeat (LAT_MAIN) step();
        chk("reseed", 1, {8'b0, o_data[1]}, 32'h00C0FFEE);

        // Randomised enable/ready traffic.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                en[k]  = ($urandom_range(0, 3) != 0);
                rdy[k] = 1'($urandom_range(0, 1));
            end
            step();
            if (i == 250) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
